udp_packet_builder: RTL and testbench
=====================================

UDP_PACKET_BUILDER -- requirements
Module: udp_packet_builder

Interface
REQ-001 SHALL have parameter MAX_PAYLOAD, default 1472, maximum accepted payload length in bytes (legal range 0..65527).
REQ-002 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, single-cycle request to build one datagram.
REQ-005 SHALL have port src_port, input, 16, UDP source port, sampled on accepted start.
REQ-006 SHALL have port dst_port, input, 16, UDP destination port, sampled on accepted start.
REQ-007 SHALL have port payload_len, input, 16, payload byte count, sampled on accepted start.
REQ-008 SHALL have port payload_data_in, input, 8, upstream payload byte.
REQ-009 SHALL have port payload_valid_in, input, 1, payload_data_in valid.
REQ-010 SHALL have port payload_ready_out, output, 1, builder accepts a payload byte this cycle.
REQ-011 SHALL have port ready_in, input, 1, downstream accepts data_out this cycle.
REQ-012 SHALL have port data_out, output, 8, datagram byte stream (header then payload).
REQ-013 SHALL have port data_valid_out, output, 1, data_out valid.
REQ-014 SHALL have port packet_start_out, output, 1, high with first header byte only.
REQ-015 SHALL have port data_last, output, 1, high with final datagram byte only.
REQ-016 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-017 SHALL have port len_error, output, 1, one-cycle registered pulse on rejected start.

Function
REQ-018 SHALL implement states IDLE, HEADER, PAYLOAD; a byte transfers on any cycle with data_valid_out & ready_in.
REQ-019 IDLE: start with payload_len <= MAX_PAYLOAD SHALL latch ports and payload_len, clear byte counters, go to HEADER next cycle.
REQ-020 IDLE: start with payload_len > MAX_PAYLOAD SHALL stay IDLE and pulse len_error for one cycle the following cycle.
REQ-021 start outside IDLE SHALL be ignored (no latch, no len_error).
REQ-022 HEADER: data_valid_out=1, data_out=header byte hdr_cnt (0..7), big-endian: src_port[15:8], src_port[7:0], dst_port[15:8], dst_port[7:0], length[15:8], length[7:0], 0x00, 0x00.
REQ-023 length SHALL equal latched payload_len + 8, computed in 16 bits (no overflow given REQ-001 range).
REQ-024 Checksum bytes SHALL be 0x0000 (checksum not computed).
REQ-025 hdr_cnt SHALL advance only on transfer; data_out SHALL hold stable while ready_in=0.
REQ-026 packet_start_out SHALL equal data_valid_out in HEADER with hdr_cnt=0; zero otherwise.
REQ-027 On transfer of header byte 7: payload_len=0 -> data_last=1 that cycle, go IDLE; else go PAYLOAD.
REQ-028 PAYLOAD: data_out=payload_data_in, data_valid_out=payload_valid_in, payload_ready_out=ready_in (combinational pass-through, zero latency).
REQ-029 payload_ready_out SHALL be 0 in IDLE and HEADER; excess upstream bytes are never consumed.
REQ-030 pay_cnt (16 bits) SHALL increment on each payload transfer; data_last=data_valid_out when pay_cnt = payload_len-1.
REQ-031 On last payload transfer SHALL go IDLE; a new start is accepted in the cycle after return to IDLE.
REQ-032 data_valid_out, data_last, packet_start_out, payload_ready_out SHALL be 0 in IDLE.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, counters 0, latched fields 0, len_error 0, busy 0, data_valid_out 0, payload_ready_out 0, data_out 0x00.
REQ-034 Reset mid-packet SHALL abort the datagram with no data_last; first start after rst_n rises is handled normally.

Verification
REQ-035 start, src=0x1234, dst=0x0050, len=4, ready_in=1, payload AA BB CC DD valid -> 12 bytes 12 34 00 50 00 0C 00 00 AA BB CC DD, packet_start_out on byte 0, data_last on DD, busy low after.
REQ-036 len=0, dst=0x1F90 -> 8 header bytes ending 00 08 00 00, data_last on byte 7, payload_ready_out never high.
REQ-037 len=2000 with MAX_PAYLOAD=1472 -> len_error one cycle, busy stays 0, no data_valid_out.
REQ-038 ready_in toggled randomly and payload_valid_in gapped during len=3 packet -> data_out stable while stalled, exact byte order, one data_last.
REQ-039 start asserted during PAYLOAD -> ignored; ports unchanged in current header; next packet only after new start in IDLE.
REQ-040 rst_n low at header byte 3 -> outputs zero immediately, no data_last; subsequent len=1 packet emits 9 correct bytes.

Source files
------------

// File: rtl/udp_packet_builder.sv
// UDP datagram framer: emits an 8-byte UDP header followed by a zero-latency
// pass-through of upstream payload bytes, with valid/ready flow control on both sides.
module udp_packet_builder #(
    parameter int MAX_PAYLOAD = 1472
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] src_port,
    input  logic [15:0] dst_port,
    input  logic [15:0] payload_len,
    input  logic [7:0]  payload_data_in,
    input  logic        payload_valid_in,
    output logic        payload_ready_out,
    input  logic        ready_in,
    output logic [7:0]  data_out,
    output logic        data_valid_out,
    output logic        packet_start_out,
    output logic        data_last,
    output logic        busy,
    output logic        len_error
);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD
    } state_t;

    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

    state_t      state;
    state_t      state_next;
    logic [2:0]  hdr_cnt;
    logic [15:0] pay_cnt;
    logic [15:0] src_q;
    logic [15:0] dst_q;
    logic [15:0] len_q;
    logic [15:0] udp_len;
    logic [7:0]  hdr_byte;
    logic        start_ok;
    logic        start_bad;
    logic        pay_last_hit;

    assign udp_len      = len_q + 16'd8;
    assign start_ok     = start && (payload_len <= MAX_LEN);
    assign start_bad    = start && (payload_len > MAX_LEN);
    assign pay_last_hit = (pay_cnt == len_q - 16'd1);
    assign busy         = (state != IDLE);

    // Checksum bytes 6 and 7 are always zero (checksum not computed).
    always_comb begin
        hdr_byte = 8'h00;
        case (hdr_cnt)
            3'd0:    hdr_byte = src_q[15:8];
            3'd1:    hdr_byte = src_q[7:0];
            3'd2:    hdr_byte = dst_q[15:8];
            3'd3:    hdr_byte = dst_q[7:0];
            3'd4:    hdr_byte = udp_len[15:8];
            3'd5:    hdr_byte = udp_len[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next        = state;
        data_out          = 8'h00;
        data_valid_out    = 1'b0;
        packet_start_out  = 1'b0;
        data_last         = 1'b0;
        payload_ready_out = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next = HEADER;
                end
            end
            HEADER: begin
                data_out         = hdr_byte;
                data_valid_out   = 1'b1;
                packet_start_out = (hdr_cnt == 3'd0);
                data_last        = (hdr_cnt == 3'd7) && (len_q == 16'd0);
                if (ready_in && (hdr_cnt == 3'd7)) begin
                    state_next = (len_q == 16'd0) ? IDLE : PAYLOAD;
                end
            end
            PAYLOAD: begin
                data_out          = payload_data_in;
                data_valid_out    = payload_valid_in;
                payload_ready_out = ready_in;
                data_last         = payload_valid_in && pay_last_hit;
                if (payload_valid_in && ready_in && pay_last_hit) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Header fields are captured only by an accepted start in IDLE; later starts are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_cnt   <= 3'd0;
            pay_cnt   <= 16'd0;
            src_q     <= 16'd0;
            dst_q     <= 16'd0;
            len_q     <= 16'd0;
            len_error <= 1'b0;
        end else begin
            len_error <= (state == IDLE) && start_bad;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        src_q   <= src_port;
                        dst_q   <= dst_port;
                        len_q   <= payload_len;
                        hdr_cnt <= 3'd0;
                        pay_cnt <= 16'd0;
                    end
                end
                HEADER: begin
                    if (ready_in) begin
                        hdr_cnt <= hdr_cnt + 3'd1;
                    end
                end
                PAYLOAD: begin
                    if (payload_valid_in && ready_in) begin
                        pay_cnt <= pay_cnt + 16'd1;
                    end
                end
                default: begin
                    hdr_cnt <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_udp_packet_builder.sv
// Self-checking bench for udp_packet_builder: randomized traffic against a byte-queue
// model of each datagram, plus directed literal checks of the header format.
module tb_udp_packet_builder;

    localparam int MAX_PAYLOAD = 1472;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] src_port = 16'h0;
    logic [15:0] dst_port = 16'h0;
    logic [15:0] payload_len = 16'h0;
    logic [7:0]  payload_data_in = 8'h0;
    logic        payload_valid_in = 1'b0;
    logic        payload_ready_out;
    logic        ready_in = 1'b0;
    logic [7:0]  data_out;
    logic        data_valid_out;
    logic        packet_start_out;
    logic        data_last;
    logic        busy;
    logic        len_error;

    udp_packet_builder #(.MAX_PAYLOAD(MAX_PAYLOAD)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .src_port         (src_port),
        .dst_port         (dst_port),
        .payload_len      (payload_len),
        .payload_data_in  (payload_data_in),
        .payload_valid_in (payload_valid_in),
        .payload_ready_out(payload_ready_out),
        .ready_in         (ready_in),
        .data_out         (data_out),
        .data_valid_out   (data_valid_out),
        .packet_start_out (packet_start_out),
        .data_last        (data_last),
        .busy             (busy),
        .len_error        (len_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model: the full expected datagram as a byte list, plus a position in it.
    logic [7:0] exp_q[$];
    logic [7:0] src_q[$];
    int  idx = 0;
    bit  in_pkt = 0;
    bit  acc_pending = 0;
    bit  last_popped = 0;
    bit  rej_now = 0;
    bit  exp_len_err = 0;
    bit  held = 0;
    bit  check_en = 0;

    bit          force_ready = 0;
    bit          force_valid = 0;
    bit          rand_start = 0;
    bit          req_start = 0;
    logic [15:0] req_src, req_dst, req_len;
    bit          use_fixed = 0;
    logic [7:0]  fixed_pay[$];

    bit         cap_en = 0;
    logic [7:0] cap_q[$];
    int cap_start_idx, cap_last_idx, cap_last_cnt, cap_pr_high, cap_lerr_cnt, cap_valid_cnt;

    task automatic expectEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic acceptStart(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
        logic [15:0] ul;
        logic [7:0]  b;
        ul = l + 16'd8;
        exp_q.delete();
        src_q.delete();
        exp_q.push_back(s[15:8]);
        exp_q.push_back(s[7:0]);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
        exp_q.push_back(ul[15:8]);
        exp_q.push_back(ul[7:0]);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        for (int i = 0; i < int'(l); i++) begin
            b = (use_fixed && i < fixed_pay.size()) ? fixed_pay[i] : 8'($urandom);
            exp_q.push_back(b);
            src_q.push_back(b);
        end
        idx = 0;
        held = 0;
        acc_pending = 1;
    endtask

    task automatic applyStimulus();
        int r;
        @(posedge clk);
        #1;
        exp_len_err = rej_now;
        rej_now = 0;
        if (last_popped) begin
            in_pkt = 0;
            last_popped = 0;
        end
        if (acc_pending) begin
            in_pkt = 1;
            acc_pending = 0;
        end
        src_port    = 16'($urandom);
        dst_port    = 16'($urandom);
        payload_len = 16'($urandom);
        start       = 1'b0;
        if (req_start) begin
            src_port    = req_src;
            dst_port    = req_dst;
            payload_len = req_len;
            start       = 1'b1;
            req_start   = 0;
        end else if (rand_start && $urandom_range(0, 5) == 0) begin
            start = 1'b1;
            r = $urandom_range(0, 9);
            if (r < 8)       payload_len = 16'($urandom_range(0, 6));
            else if (r == 8) payload_len = 16'(MAX_PAYLOAD + $urandom_range(1, 600));
            else             payload_len = 16'h0;
        end
        if (start && rst_n && !in_pkt) begin
            if (int'(payload_len) <= MAX_PAYLOAD) acceptStart(src_port, dst_port, payload_len);
            else rej_now = 1;
        end
        ready_in = force_ready ? 1'b1 : ($urandom_range(0, 2) != 0);
        if (src_q.size() > 0) begin
            payload_data_in  = src_q[0];
            payload_valid_in = (held || force_valid) ? 1'b1 : 1'($urandom_range(0, 1));
        end else begin
            payload_data_in  = 8'hEE;
            payload_valid_in = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic checkOutput();
        bit   hdr, ev, er, consumed;
        int   n;
        n = exp_q.size();
        expectEq("busy", busy, in_pkt);
        expectEq("len_error", len_error, exp_len_err);
        if (in_pkt && idx < n) begin
            hdr = (idx < 8);
            ev  = hdr ? 1'b1 : payload_valid_in;
            er  = hdr ? 1'b0 : ready_in;
            expectEq("data_valid_out", data_valid_out, ev);
            expectEq("payload_ready_out", payload_ready_out, er);
            expectEq("packet_start_out", packet_start_out, ev && idx == 0);
            expectEq("data_last", data_last, ev && idx == n - 1);
            if (ev) expectEq("data_out", data_out, exp_q[idx]);
            consumed = !hdr && payload_valid_in && ready_in;
            held = payload_valid_in && (src_q.size() > 0) && !consumed;
            if (ev && ready_in) begin
                if (!hdr) void'(src_q.pop_front());
                idx++;
                if (idx == n) last_popped = 1;
            end
        end else begin
            expectEq("idle_valid", data_valid_out, 0);
            expectEq("idle_ready_out", payload_ready_out, 0);
            expectEq("idle_start", packet_start_out, 0);
            expectEq("idle_last", data_last, 0);
            expectEq("idle_data", data_out, 0);
            held = 0;
        end
        if (cap_en) begin
            if (data_valid_out && ready_in) begin
                if (packet_start_out) cap_start_idx = cap_q.size();
                if (data_last) begin
                    cap_last_idx = cap_q.size();
                    cap_last_cnt++;
                end
                cap_q.push_back(data_out);
            end
            if (payload_ready_out) cap_pr_high++;
            if (len_error) cap_lerr_cnt++;
            if (data_valid_out) cap_valid_cnt++;
        end
    endtask

    always @(negedge clk) begin
        if (check_en && rst_n) checkOutput();
    end

    task automatic checkZero(input string tag);
        expectEq({tag, "_data_out"}, data_out, 0);
        expectEq({tag, "_valid"}, data_valid_out, 0);
        expectEq({tag, "_ready_out"}, payload_ready_out, 0);
        expectEq({tag, "_start"}, packet_start_out, 0);
        expectEq({tag, "_last"}, data_last, 0);
        expectEq({tag, "_busy"}, busy, 0);
        expectEq({tag, "_len_error"}, len_error, 0);
    endtask

    task automatic clearCapture();
        cap_q.delete();
        cap_start_idx = -1;
        cap_last_idx  = -1;
        cap_last_cnt  = 0;
        cap_pr_high   = 0;
        cap_lerr_cnt  = 0;
        cap_valid_cnt = 0;
    endtask

    task automatic requestStart(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
        req_src = s;
        req_dst = d;
        req_len = l;
        req_start = 1;
    endtask

    task automatic waitIdle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            applyStimulus();
            if (!in_pkt && !acc_pending && !req_start) break;
        end
        expectEq("wait_idle_timeout", in_pkt || acc_pending, 0);
    endtask

    task automatic clearModel();
        exp_q.delete();
        src_q.delete();
        idx = 0;
        in_pkt = 0;
        acc_pending = 0;
        last_popped = 0;
        rej_now = 0;
        exp_len_err = 0;
        held = 0;
        req_start = 0;
    endtask

    logic [7:0] lit035 [12] = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h00, 8'h0C,
                                8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [7:0] lit036 [8]  = '{8'hBE, 8'hEF, 8'h1F, 8'h90, 8'h00, 8'h08, 8'h00, 8'h00};

    initial begin
        #3;
        checkZero("reset");
        #9;
        rst_n = 1'b1;
        check_en = 1;

        // Basic 4-byte datagram with literal header and payload.
        $display("[TB] directed len=4 packet");
        force_ready = 1;
        force_valid = 1;
        use_fixed = 1;
        fixed_pay = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        clearCapture();
        cap_en = 1;
        requestStart(16'h1234, 16'h0050, 16'd4);
        waitIdle(100);
        cap_en = 0;
        use_fixed = 0;
        expectEq("t035_count", cap_q.size(), 12);
        for (int i = 0; i < 12 && i < cap_q.size(); i++) expectEq("t035_byte", cap_q[i], lit035[i]);
        expectEq("t035_start_idx", cap_start_idx, 0);
        expectEq("t035_last_idx", cap_last_idx, 11);
        expectEq("t035_last_cnt", cap_last_cnt, 1);
        expectEq("t035_busy_after", busy, 0);

        // Empty payload: header only, last on byte 7.
        $display("[TB] directed len=0 packet");
        clearCapture();
        cap_en = 1;
        requestStart(16'hBEEF, 16'h1F90, 16'd0);
        waitIdle(50);
        cap_en = 0;
        expectEq("t036_count", cap_q.size(), 8);
        for (int i = 0; i < 8 && i < cap_q.size(); i++) expectEq("t036_byte", cap_q[i], lit036[i]);
        expectEq("t036_last_idx", cap_last_idx, 7);
        expectEq("t036_ready_out_seen", cap_pr_high, 0);

        // Oversize requests are rejected with a one-cycle len_error.
        $display("[TB] directed oversize requests");
        clearCapture();
        cap_en = 1;
        requestStart(16'h1111, 16'h2222, 16'd2000);
        repeat (5) applyStimulus();
        cap_en = 0;
        expectEq("t037_len_error_cycles", cap_lerr_cnt, 1);
        expectEq("t037_valid_cycles", cap_valid_cnt, 0);
        clearCapture();
        cap_en = 1;
        requestStart(16'h1111, 16'h2222, 16'(MAX_PAYLOAD + 1));
        repeat (5) applyStimulus();
        cap_en = 0;
        expectEq("max_plus1_len_error_cycles", cap_lerr_cnt, 1);

        // Largest legal payload is accepted.
        clearCapture();
        cap_en = 1;
        requestStart(16'h0102, 16'h0304, 16'(MAX_PAYLOAD));
        waitIdle(MAX_PAYLOAD + 50);
        cap_en = 0;
        expectEq("max_count", cap_q.size(), MAX_PAYLOAD + 8);
        expectEq("max_len_hi", cap_q.size() > 5 ? cap_q[4] : 8'hXX, 8'h05);
        expectEq("max_len_lo", cap_q.size() > 5 ? cap_q[5] : 8'hXX, 8'hC8);
        expectEq("max_last_cnt", cap_last_cnt, 1);

        // Stalled downstream and gapped upstream.
        $display("[TB] stalls and gaps");
        force_ready = 0;
        force_valid = 0;
        clearCapture();
        cap_en = 1;
        requestStart(16'hA5A5, 16'h5A5A, 16'd3);
        waitIdle(300);
        cap_en = 0;
        expectEq("t038_count", cap_q.size(), 11);
        expectEq("t038_last_cnt", cap_last_cnt, 1);
        expectEq("t038_last_idx", cap_last_idx, 10);

        // A start issued mid-payload must be ignored.
        $display("[TB] start during payload");
        requestStart(16'hCAFE, 16'hF00D, 16'd5);
        for (int i = 0; i < 300 && !(in_pkt && idx >= 9); i++) applyStimulus();
        expectEq("t039_reached_payload", in_pkt && idx >= 9, 1);
        requestStart(16'h9999, 16'h8888, 16'd2);
        applyStimulus();
        waitIdle(300);
        repeat (6) applyStimulus();
        expectEq("t039_no_new_packet", busy, 0);

        // Reset in the middle of the header, then a normal 1-byte packet.
        $display("[TB] reset mid-header");
        force_ready = 1;
        requestStart(16'h4321, 16'h8765, 16'd5);
        for (int i = 0; i < 40 && !(in_pkt && idx == 3); i++) applyStimulus();
        expectEq("t040_reached_byte3", in_pkt && idx == 3, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkZero("midreset");
        clearModel();
        repeat (2) applyStimulus();
        clearModel();
        rst_n = 1'b1;
        force_ready = 0;
        clearCapture();
        cap_en = 1;
        requestStart(16'h0A0B, 16'h0C0D, 16'd1);
        waitIdle(100);
        cap_en = 0;
        expectEq("t040_count", cap_q.size(), 9);
        expectEq("t040_last_cnt", cap_last_cnt, 1);
        expectEq("t040_len_lo", cap_q.size() > 5 ? cap_q[5] : 8'hXX, 8'h09);

        // Randomized traffic.
        $display("[TB] random traffic");
        rand_start = 1;
        for (int i = 0; i < 4000; i++) applyStimulus();
        rand_start = 0;
        waitIdle(3000);

        check_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
